fft8_radix2: RTL and testbench

- Parallel-I/O 8-point radix-2 decimation-in-time FFT.
- Operates on complex samples in signed Q8.8 (0x0100 = 1.0).
- Loads all eight inputs in one write cycle, computes over three pipelined butterfly stages, and presents all eight outputs in natural order with a ready flag.
- Used as a standalone spectral-transform block fed by a frame buffer.

---
 rtl/fft8_radix2_if.sv | 23 ++
 rtl/fft8_radix2.sv | 205 ++++++++++++++++++++
 tb/tb_fft8_radix2.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fft8_radix2_if.sv
// Parallel sample bus for fft8_radix2: write/start controls, eight complex
// inputs, eight complex outputs and the ready flag.
interface fft8_radix2_if #(
  parameter int DW = 16
);
  logic                 write;
  logic                 start;
  logic signed [DW-1:0] input_real  [8];
  logic signed [DW-1:0] input_imag  [8];
  logic signed [DW-1:0] output_real [8];
  logic signed [DW-1:0] output_imag [8];
  logic                 ready;

  modport master (
    output write, start, input_real, input_imag,
    input  output_real, output_imag, ready
  );

  modport slave (
    input  write, start, input_real, input_imag,
    output output_real, output_imag, ready
  );
endinterface

// File: rtl/fft8_radix2.sv
// Parallel-I/O 8-point radix-2 DIT FFT, Q8.8 samples, three registered butterfly stages.
// Optional macro FFT_SCALE_EN halves every butterfly sum so outputs are X[K]/8.
module fft8_radix2 #(
  parameter int DW = 16,
  parameter int TW = 16
) (
  input  logic         clk,
  input  logic         rst,
  fft8_radix2_if.slave bus
);

  localparam int IW   = 19;
  localparam int PW   = IW + TW + 1;
  localparam int FRAC = TW - 2;

  typedef struct packed {
    logic signed [IW-1:0] re;
    logic signed [IW-1:0] im;
  } cplx_t;

  typedef enum logic [2:0] {IDLE, ST1, ST2, ST3, WAIT} state_t;

  localparam logic signed [TW-1:0] W1_RE   = TW'(11585);
  localparam logic signed [TW-1:0] W1_IM   = TW'(-11585);
  localparam logic signed [TW-1:0] W3_RE   = TW'(-11585);
  localparam logic signed [TW-1:0] W3_IM   = TW'(-11585);
  localparam logic signed [IW-1:0] SAT_MAX = IW'((1 <<< (DW-1)) - 1);
  localparam logic signed [IW-1:0] SAT_MIN = IW'(-(1 <<< (DW-1)));
  localparam int                   BITREV [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  state_t               state_q, state_d;
  logic                 ready_q, ready_d;
  logic                 load;
  cplx_t                buf_q      [8];
  cplx_t                buf_d      [8];
  cplx_t                s1_p0_q    [8];
  cplx_t                s1_p0_d    [8];
  cplx_t                s2_p1_q    [8];
  cplx_t                s2_p1_d    [8];
  logic signed [DW-1:0] out_re_p2_q [8];
  logic signed [DW-1:0] out_re_p2_d [8];
  logic signed [DW-1:0] out_im_p2_q [8];
  logic signed [DW-1:0] out_im_p2_d [8];
  cplx_t                s1_c       [8];
  cplx_t                s2_c       [8];
  cplx_t                s3_c       [8];

  function automatic logic signed [IW-1:0] scl(input logic signed [IW-1:0] v);
`ifdef FFT_SCALE_EN
    return v >>> 1;
`else
    return v;
`endif
  endfunction

  function automatic cplx_t bfly_add(input cplx_t a, input cplx_t b);
    cplx_t r;
    r.re = scl(a.re + b.re);
    r.im = scl(a.im + b.im);
    return r;
  endfunction

  function automatic cplx_t bfly_sub(input cplx_t a, input cplx_t b);
    cplx_t r;
    r.re = scl(a.re - b.re);
    r.im = scl(a.im - b.im);
    return r;
  endfunction

  // Full-precision complex product, then floor back to the Q8.8 grid.
  function automatic cplx_t cmul(input cplx_t b, input logic signed [TW-1:0] wr,
                                 input logic signed [TW-1:0] wi);
    logic signed [PW-1:0] pr;
    logic signed [PW-1:0] pi;
    cplx_t r;
    pr   = PW'(b.re) * PW'(wr) - PW'(b.im) * PW'(wi);
    pi   = PW'(b.re) * PW'(wi) + PW'(b.im) * PW'(wr);
    r.re = IW'(pr >>> FRAC);
    r.im = IW'(pi >>> FRAC);
    return r;
  endfunction

  // W8^k; W0 passes through and W2 is an exact multiply by -j.
  function automatic cplx_t twiddle(input cplx_t b, input logic [1:0] k);
    cplx_t r;
    case (k)
      2'd0:    r = b;
      2'd1:    r = cmul(b, W1_RE, W1_IM);
      2'd2:    begin r.re = b.im; r.im = -b.re; end
      default: r = cmul(b, W3_RE, W3_IM);
    endcase
    return r;
  endfunction

  function automatic logic signed [DW-1:0] sat(input logic signed [IW-1:0] v);
    if (v > SAT_MAX) return DW'(SAT_MAX);
    if (v < SAT_MIN) return DW'(SAT_MIN);
    return DW'(v);
  endfunction

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        load = bus.write;
        if (bus.start) begin
          state_d = ST1;
          ready_d = 1'b0;
        end
      end
      ST1: state_d = ST2;
      ST2: state_d = ST3;
      ST3: begin
        state_d = WAIT;
        ready_d = 1'b1;
      end
      WAIT: begin
        load = bus.write;
        if (!bus.start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage 1: span-1 butterflies on the bit-reversed buffer
  always_comb begin
    for (int m = 0; m < 4; m++) begin
      s1_c[2*m]   = bfly_add(buf_q[BITREV[2*m]], buf_q[BITREV[2*m+1]]);
      s1_c[2*m+1] = bfly_sub(buf_q[BITREV[2*m]], buf_q[BITREV[2*m+1]]);
    end
  end

  // Stage 2: span-2 butterflies, twiddles W0 / W2
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      for (int j = 0; j < 2; j++) begin
        s2_c[4*g+j]   = bfly_add(s1_p0_q[4*g+j], twiddle(s1_p0_q[4*g+j+2], 2'(2*j)));
        s2_c[4*g+j+2] = bfly_sub(s1_p0_q[4*g+j], twiddle(s1_p0_q[4*g+j+2], 2'(2*j)));
      end
    end
  end

  // Stage 3: span-4 butterflies, twiddles W0..W3, natural-order result
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      s3_c[j]   = bfly_add(s2_p1_q[j], twiddle(s2_p1_q[j+4], 2'(j)));
      s3_c[j+4] = bfly_sub(s2_p1_q[j], twiddle(s2_p1_q[j+4], 2'(j)));
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      buf_d[i]       = buf_q[i];
      s1_p0_d[i]     = s1_p0_q[i];
      s2_p1_d[i]     = s2_p1_q[i];
      out_re_p2_d[i] = out_re_p2_q[i];
      out_im_p2_d[i] = out_im_p2_q[i];
      if (load) begin
        buf_d[i].re = IW'(bus.input_real[i]);
        buf_d[i].im = IW'(bus.input_imag[i]);
      end
      if (state_q == ST1) s1_p0_d[i] = s1_c[i];
      if (state_q == ST2) s2_p1_d[i] = s2_c[i];
      if (state_q == ST3) begin
        out_re_p2_d[i] = sat(s3_c[i].re);
        out_im_p2_d[i] = sat(s3_c[i].im);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        buf_q[i]       <= '0;
        s1_p0_q[i]     <= '0;
        s2_p1_q[i]     <= '0;
        out_re_p2_q[i] <= '0;
        out_im_p2_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      for (int i = 0; i < 8; i++) begin
        buf_q[i]       <= buf_d[i];
        s1_p0_q[i]     <= s1_p0_d[i];
        s2_p1_q[i]     <= s2_p1_d[i];
        out_re_p2_q[i] <= out_re_p2_d[i];
        out_im_p2_q[i] <= out_im_p2_d[i];
      end
    end
  end

  always_comb begin
    bus.ready = ready_q;
    for (int k = 0; k < 8; k++) begin
      bus.output_real[k] = out_re_p2_q[k];
      bus.output_imag[k] = out_im_p2_q[k];
    end
  end

endmodule

// File: tb/tb_fft8_radix2.sv
// Scoreboard bench for fft8_radix2: a direct-DFT reference model queues expected
// spectra at start time; a monitor compares them when ready rises.
module tb_fft8_radix2;
  localparam int  DW = 16;
  localparam real PI = 3.14159265358979323846;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   exp_q [$];
  int   tol_q [$];
  int   rc_q  [$];
  int   a_re [8];
  int   a_im [8];

  fft8_radix2_if #(.DW(DW)) bus ();

  fft8_radix2 #(.DW(DW), .TW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv, input int tol);
    total++;
    if (act - expv > tol || expv - act > tol) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d tol=%0d", name, act, expv, tol);
    end
  endtask

  function automatic int sat16(input real v);
    if (v >= 32767.0) return 32767;
    if (v <= -32768.0) return -32768;
    return int'(v);
  endfunction

  // Reference: textbook 8-point DFT in real arithmetic, then saturation.
  task automatic push_expect(input int xr[8], input int xi[8], input int tol, input int rc);
    real sr, si, ang;
    for (int k = 0; k < 8; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < 8; n++) begin
        ang = -2.0 * PI * real'(k * n) / 8.0;
        sr += real'(xr[n]) * $cos(ang) - real'(xi[n]) * $sin(ang);
        si += real'(xr[n]) * $sin(ang) + real'(xi[n]) * $cos(ang);
      end
      exp_q.push_back(sat16(sr));
      exp_q.push_back(sat16(si));
    end
    tol_q.push_back(tol);
    rc_q.push_back(rc);
  endtask

  task automatic drive_inputs(input int xr[8], input int xi[8]);
    for (int i = 0; i < 8; i++) begin
      bus.input_real[i] = DW'(xr[i]);
      bus.input_imag[i] = DW'(xi[i]);
    end
  endtask

  task automatic rand_frame(output int xr[8], output int xi[8]);
    for (int i = 0; i < 8; i++) begin
      xr[i] = int'($urandom_range(0, 8191)) - 4096;
      xi[i] = int'($urandom_range(0, 8191)) - 4096;
    end
  endtask

  // One transform with start held until well after ready.
  task automatic run_fft(input int xr[8], input int xi[8], input int tol,
                         input bit same_edge, input bit write_during);
    int jr [8];
    int ji [8];
    int n;
    @(negedge clk);
    drive_inputs(xr, xi);
    bus.write = 1'b1;
    bus.start = same_edge;
    if (!same_edge) begin
      @(negedge clk);
      bus.write = 1'b0;
      bus.start = 1'b1;
    end
    push_expect(xr, xi, tol, cyc + 4);
    @(negedge clk);
    bus.write = 1'b0;
    chk("ready_clear_on_start", int'(bus.ready), 0, 0);
    if (write_during) begin
      rand_frame(jr, ji);
      drive_inputs(jr, ji);
      bus.write = 1'b1;
      repeat (3) @(negedge clk);
      bus.write = 1'b0;
    end
    n = 0;
    while (!bus.ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) chk("ready_timeout", 0, 1, 0);
    repeat (3) begin
      @(negedge clk);
      chk("ready_held_with_start", int'(bus.ready), 1, 0);
    end
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: each ready rise consumes one queued expectation.
  initial begin
    logic prev;
    int   tol;
    int   rc;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ready && !prev) begin
        if (rc_q.size() == 0) begin
          chk("unexpected_ready", 1, 0, 0);
        end else begin
          tol = tol_q.pop_front();
          rc  = rc_q.pop_front();
          chk("ready_latency", cyc, rc, 0);
          for (int k = 0; k < 8; k++) begin
            chk($sformatf("X%0d_re", k), int'(bus.output_real[k]), exp_q.pop_front(), tol);
            chk($sformatf("X%0d_im", k), int'(bus.output_imag[k]), exp_q.pop_front(), tol);
          end
        end
      end
      prev = bus.ready;
    end
  end

  initial begin
    int zr [8];
    int zi [8];
    rst       = 1'b1;
    bus.write = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      zr[i] = 0;
      zi[i] = 0;
    end
    drive_inputs(zr, zi);
    #1 rst = 1'b0;
    #2;
    chk("reset_ready", int'(bus.ready), 0, 0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("reset_X%0d_re", k), int'(bus.output_real[k]), 0, 0);
      chk($sformatf("reset_X%0d_im", k), int'(bus.output_imag[k]), 0, 0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin a_re[i] = i * 256; a_im[i] = 0; end
    run_fft(a_re, a_im, 2, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin a_re[i] = (i == 0) ? 256 : 0; a_im[i] = 0; end
    run_fft(a_re, a_im, 0, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) begin a_re[i] = 256; a_im[i] = 0; end
    run_fft(a_re, a_im, 0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin a_re[i] = 32767; a_im[i] = 0; end
    run_fft(a_re, a_im, 0, 1'b1, 1'b0);

    rand_frame(a_re, a_im);
    run_fft(a_re, a_im, 3, 1'b0, 1'b1);

    // Reset while the FSM sits in ST2; that transform is discarded.
    rand_frame(a_re, a_im);
    @(negedge clk);
    drive_inputs(a_re, a_im);
    bus.write = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_ready", int'(bus.ready), 0, 0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("midrst_X%0d_re", k), int'(bus.output_real[k]), 0, 0);
      chk($sformatf("midrst_X%0d_im", k), int'(bus.output_imag[k]), 0, 0);
    end
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    rand_frame(a_re, a_im);
    run_fft(a_re, a_im, 3, 1'b1, 1'b0);

    for (int t = 0; t < 20; t++) begin
      rand_frame(a_re, a_im);
      run_fft(a_re, a_im, 3, t[0], t[1]);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", rc_q.size(), 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
